// File: rtl/music_pkg.sv
// Shared definitions for the note interface between the controller and the
// tone generator: note and octave codes, middle-octave half-period table
// (in clk cycles at 100 MHz) and the tone generator state encoding.
package music_pkg;

    localparam logic [3:0] NOTE_REST = 4'd0;
    localparam logic [3:0] NOTE_DO   = 4'd1;
    localparam logic [3:0] NOTE_RE   = 4'd2;
    localparam logic [3:0] NOTE_MI   = 4'd3;
    localparam logic [3:0] NOTE_FA   = 4'd4;
    localparam logic [3:0] NOTE_SOL  = 4'd5;
    localparam logic [3:0] NOTE_LA   = 4'd6;
    localparam logic [3:0] NOTE_TI   = 4'd7;

    // 2'b11 is not a distinct code; it decodes as middle like 2'b00.
    localparam logic [1:0] OCT_MID  = 2'b00;
    localparam logic [1:0] OCT_LOW  = 2'b01;
    localparam logic [1:0] OCT_HIGH = 2'b10;

    localparam int unsigned HP_DO  = 191110;
    localparam int unsigned HP_RE  = 170265;
    localparam int unsigned HP_MI  = 151685;
    localparam int unsigned HP_FA  = 143172;
    localparam int unsigned HP_SOL = 127551;
    localparam int unsigned HP_LA  = 113636;
    localparam int unsigned HP_TI  = 101239;

    typedef enum logic [1:0] {
        SILENT = 2'd0,
        PLAY   = 2'd1,
        GAP    = 2'd2
    } tone_state_e;

    // Codes 8..15 are invalid and behave exactly like a rest.
    function automatic logic note_is_valid(input logic [3:0] note);
        return (note != NOTE_REST) && (note <= NOTE_TI);
    endfunction

endpackage

// File: rtl/tone_generator_if.sv
// Note interface from the controller to the tone generator.
//   note_in     : 4-bit note code (0 rest, 1..7 do..ti, 8..15 treated as rest)
//   octave_in   : 2-bit octave code (01 low, 10 high, 00/11 middle)
//   retrigger   : one-cycle pulse to re-strike the current note
//   active_note : note being sounded, 0 when not playing
//   busy        : generator is playing or holding an articulation gap
// The controller uses the master modport, the tone generator the slave.
interface tone_generator_if;

    logic [3:0] note_in;
    logic [1:0] octave_in;
    logic       retrigger;
    logic [3:0] active_note;
    logic       busy;

    modport master (
        output note_in,
        output octave_in,
        output retrigger,
        input  active_note,
        input  busy
    );

    modport slave (
        input  note_in,
        input  octave_in,
        input  retrigger,
        output active_note,
        output busy
    );

endinterface

// File: rtl/tone_period_lut.sv
// Combinational half-period lookup for the square-wave generator.
//   note        : 4-bit note code
//   octave      : 2-bit octave code
//   half_period : half-period in clk cycles; 0 for rest/invalid codes,
//                 which the caller never loads
module tone_period_lut
    import music_pkg::*;
#(
    parameter int CNT_W = 20
) (
    input  logic [3:0]       note,
    input  logic [1:0]       octave,
    output logic [CNT_W-1:0] half_period
);

    logic [CNT_W-1:0] base;

    always_comb begin
        case (note)
            NOTE_DO:  base = CNT_W'(HP_DO);
            NOTE_RE:  base = CNT_W'(HP_RE);
            NOTE_MI:  base = CNT_W'(HP_MI);
            NOTE_FA:  base = CNT_W'(HP_FA);
            NOTE_SOL: base = CNT_W'(HP_SOL);
            NOTE_LA:  base = CNT_W'(HP_LA);
            NOTE_TI:  base = CNT_W'(HP_TI);
            default:  base = '0;
        endcase

        // Octave scaling is a plain shift of the middle-octave value.
        case (octave)
            OCT_LOW:  half_period = base << 1;
            OCT_HIGH: half_period = base >> 1;
            default:  half_period = base;
        endcase
    end

endmodule

// File: rtl/tone_generator.sv
// Square-wave tone generator driving the board's mono audio output.
// Plays the note requested on the note interface and inserts a silent
// articulation gap between different consecutive notes and on re-strike.
//   clk      : 100 MHz system clock
//   reset    : asynchronous, active-high reset
//   note_bus : note interface (slave side), see tone_generator_if
//   speaker  : square-wave audio output
//   amp_en   : amplifier enable, high only while playing
module tone_generator
    import music_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 2_000_000,
    parameter int          CNT_W      = 20
) (
    input  logic             clk,
    input  logic             reset,
    tone_generator_if.slave  note_bus,
    output logic             speaker,
    output logic             amp_en
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    tone_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [3:0]       note_q, note_d;
    logic [1:0]       oct_q, oct_d;
    logic             spk_q, spk_d;

    logic [CNT_W-1:0] lut_half;
    logic             in_valid;
    logic             in_changed;
    logic             gap_done;

    tone_period_lut #(
        .CNT_W (CNT_W)
    ) u_lut (
        .note        (note_bus.note_in),
        .octave      (note_bus.octave_in),
        .half_period (lut_half)
    );

    assign in_valid   = note_is_valid(note_bus.note_in);
    // An octave-only change counts as a new note.
    assign in_changed = {note_bus.note_in, note_bus.octave_in} != {note_q, oct_q};
    assign gap_done   = (gap_q == GAP_W'(GAP_CYCLES - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        half_d  = half_q;
        gap_d   = gap_q;
        note_d  = note_q;
        oct_d   = oct_q;
        spk_d   = spk_q;

        case (state_q)
            SILENT: begin
                spk_d = 1'b0;
                cnt_d = '0;
                gap_d = '0;
                if (in_valid) begin
                    note_d  = note_bus.note_in;
                    oct_d   = note_bus.octave_in;
                    half_d  = lut_half;
                    state_d = PLAY;
                end
            end

            PLAY: begin
                // An input change takes priority over a simultaneous retrigger.
                if (in_changed) begin
                    spk_d   = 1'b0;
                    cnt_d   = '0;
                    gap_d   = '0;
                    state_d = in_valid ? GAP : SILENT;
                end else if (note_bus.retrigger) begin
                    spk_d   = 1'b0;
                    cnt_d   = '0;
                    gap_d   = '0;
                    state_d = GAP;
                end else if (cnt_q == half_q - CNT_W'(1)) begin
                    cnt_d = '0;
                    spk_d = ~spk_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            GAP: begin
                // The gap is never restarted; only the input at its last
                // cycle decides what follows.
                spk_d = 1'b0;
                cnt_d = '0;
                if (gap_done) begin
                    gap_d = '0;
                    if (in_valid) begin
                        note_d  = note_bus.note_in;
                        oct_d   = note_bus.octave_in;
                        half_d  = lut_half;
                        state_d = PLAY;
                    end else begin
                        state_d = SILENT;
                    end
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end

            default: begin
                spk_d   = 1'b0;
                cnt_d   = '0;
                gap_d   = '0;
                state_d = SILENT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= SILENT;
            cnt_q   <= '0;
            half_q  <= '0;
            gap_q   <= '0;
            note_q  <= '0;
            oct_q   <= '0;
            spk_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            half_q  <= half_d;
            gap_q   <= gap_d;
            note_q  <= note_d;
            oct_q   <= oct_d;
            spk_q   <= spk_d;
        end
    end

    assign speaker              = spk_q;
    assign amp_en               = (state_q == PLAY);
    assign note_bus.busy        = (state_q != SILENT);
    assign note_bus.active_note = (state_q == PLAY) ? note_q : NOTE_REST;

endmodule

// File: tb/tb_tone_generator.sv
// Testbench for tone_generator. Stimulus pushes the expected output
// changes (cycle number and {speaker, amp_en, busy, active_note}) into a
// queue; a monitor compares every observed output change against it.
module tb_tone_generator;

    logic       clk;
    logic       reset;
    logic       speaker;
    logic       amp_en;
    logic [6:0] outs;
    int         cyc;

    tone_generator_if bus();

    tone_generator #(
        .GAP_CYCLES (8),
        .CNT_W      (20)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .note_bus (bus),
        .speaker  (speaker),
        .amp_en   (amp_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    assign outs = {speaker, amp_en, bus.busy, bus.active_note};

    typedef struct {
        string      name;
        int         at;
        logic [6:0] outs;
    } exp_t;

    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    bit         mon_en   = 1'b0;
    bit         done     = 1'b0;
    bit         seen_rst = 1'b0;
    logic [6:0] prev_outs = '0;

    // Monitor: every change of the observed outputs must match the next
    // queued expectation, both in value and in the cycle it appeared.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (mon_en) begin
            if (!seen_rst) begin
                n_checks++;
                if (outs === 7'd0) n_pass++;
                else $display("[TB] FAIL reset_state: got outs=%b, expected outs=%b", outs, 7'd0);
                seen_rst <= 1'b1;
            end else if (outs !== prev_outs) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("[TB] FAIL unexpected_change: got outs=%b at cycle %0d, expected no change (outs=%b)",
                             outs, cyc, prev_outs);
                end else begin
                    e = exp_q.pop_front();
                    if (e.at == cyc && e.outs === outs) n_pass++;
                    else $display("[TB] FAIL %s: got outs=%b at cycle %0d, expected outs=%b at cycle %0d",
                                  e.name, outs, cyc, e.outs, e.at);
                end
            end
            prev_outs <= outs;
        end
        if (done) begin
            n_checks++;
            if (exp_q.size() == 0) n_pass++;
            else $display("[TB] FAIL missing_events: got %0d unseen expected changes (next %s), expected 0",
                          exp_q.size(), exp_q[0].name);
            $display("%0d/%0d checks passed", n_pass, n_checks);
            $finish;
        end
    end

    task automatic expect_evt(input string name, input int at, input logic spk,
                              input logic amp, input logic bsy, input logic [3:0] note);
        exp_t e;
        e.name = name;
        e.at   = at;
        e.outs = {spk, amp, bsy, note};
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic apply_stimulus(input logic [3:0] note, input logic [1:0] oct);
        bus.note_in   = note;
        bus.octave_in = oct;
    endtask

    task automatic pulse_retrigger();
        bus.retrigger = 1'b1;
        tick(1);
        bus.retrigger = 1'b0;
    endtask

    // Assert reset a little after a rising edge so an asynchronous clear is
    // visible within the same cycle, then release it with the inputs at rest.
    task automatic async_reset(input string name);
        @(posedge clk);
        #2;
        expect_evt(name, cyc, 1'b0, 1'b0, 1'b0, 4'd0);
        reset = 1'b1;
        tick(3);
        apply_stimulus(4'd0, 2'b00);
        reset = 1'b0;
        tick(1);
    endtask

    initial begin : stimulus
        int t;
        reset         = 1'b0;
        bus.note_in   = 4'd0;
        bus.octave_in = 2'b00;
        bus.retrigger = 1'b0;
        #1 reset = 1'b1;
        tick(2);
        mon_en = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(2);

        $display("[TB] note 6 middle octave");
        t = cyc;
        expect_evt("la_play",  t + 1,          1'b0, 1'b1, 1'b1, 4'd6);
        expect_evt("la_rise",  t + 1 + 113636, 1'b1, 1'b1, 1'b1, 4'd6);
        expect_evt("la_fall",  t + 1 + 227272, 1'b0, 1'b1, 1'b1, 4'd6);
        apply_stimulus(4'd6, 2'b00);
        wait_until(t + 1 + 227272 + 5);
        t = cyc;
        expect_evt("la_stop",  t + 1,          1'b0, 1'b0, 1'b0, 4'd0);
        apply_stimulus(4'd0, 2'b00);
        tick(3);

        $display("[TB] note 1 low then high octave");
        t = cyc;
        expect_evt("do_low_play", t + 1,          1'b0, 1'b1, 1'b1, 4'd1);
        expect_evt("do_low_rise", t + 1 + 382220, 1'b1, 1'b1, 1'b1, 4'd1);
        apply_stimulus(4'd1, 2'b01);
        wait_until(t + 1 + 382220 + 5);
        t = cyc;
        expect_evt("octave_gap",   t + 1,         1'b0, 1'b0, 1'b1, 4'd0);
        expect_evt("do_high_play", t + 9,         1'b0, 1'b1, 1'b1, 4'd1);
        expect_evt("do_high_rise", t + 9 + 95555, 1'b1, 1'b1, 1'b1, 4'd1);
        apply_stimulus(4'd1, 2'b10);
        wait_until(t + 9 + 95555 + 5);
        t = cyc;
        expect_evt("do_high_stop", t + 1,         1'b0, 1'b0, 1'b0, 4'd0);
        apply_stimulus(4'd0, 2'b00);
        tick(3);

        $display("[TB] input changes during gap");
        t = cyc;
        expect_evt("mi_play", t + 1, 1'b0, 1'b1, 1'b1, 4'd3);
        apply_stimulus(4'd3, 2'b00);
        tick(4);
        t = cyc;
        expect_evt("mi_sol_gap", t + 1,          1'b0, 1'b0, 1'b1, 4'd0);
        expect_evt("sol_play",   t + 9,          1'b0, 1'b1, 1'b1, 4'd5);
        expect_evt("sol_rise",   t + 9 + 127551, 1'b1, 1'b1, 1'b1, 4'd5);
        apply_stimulus(4'd5, 2'b00);
        tick(3);
        apply_stimulus(4'd7, 2'b00);
        tick(2);
        apply_stimulus(4'd5, 2'b00);
        wait_until(t + 9 + 127551 + 5);
        t = cyc;
        expect_evt("sol_stop", t + 1, 1'b0, 1'b0, 1'b0, 4'd0);
        apply_stimulus(4'd0, 2'b00);
        tick(3);

        $display("[TB] rest and invalid codes stop playback");
        t = cyc;
        expect_evt("re_play", t + 1,          1'b0, 1'b1, 1'b1, 4'd2);
        expect_evt("re_rise", t + 1 + 170265, 1'b1, 1'b1, 1'b1, 4'd2);
        apply_stimulus(4'd2, 2'b00);
        wait_until(t + 1 + 170265 + 5);
        t = cyc;
        expect_evt("re_rest_stop", t + 1, 1'b0, 1'b0, 1'b0, 4'd0);
        apply_stimulus(4'd0, 2'b00);
        tick(3);
        t = cyc;
        expect_evt("re_replay", t + 1, 1'b0, 1'b1, 1'b1, 4'd2);
        apply_stimulus(4'd2, 2'b00);
        tick(5);
        t = cyc;
        expect_evt("re_invalid_stop", t + 1, 1'b0, 1'b0, 1'b0, 4'd0);
        apply_stimulus(4'd9, 2'b00);
        tick(3);
        apply_stimulus(4'd0, 2'b00);
        tick(3);

        $display("[TB] retrigger");
        t = cyc;
        expect_evt("fa_play", t + 1, 1'b0, 1'b1, 1'b1, 4'd4);
        apply_stimulus(4'd4, 2'b00);
        tick(20);
        t = cyc;
        expect_evt("retrig_gap",  t + 1,          1'b0, 1'b0, 1'b1, 4'd0);
        expect_evt("fa_restrike", t + 9,          1'b0, 1'b1, 1'b1, 4'd4);
        expect_evt("fa_rise",     t + 9 + 143172, 1'b1, 1'b1, 1'b1, 4'd4);
        pulse_retrigger();
        wait_until(t + 9 + 143172 + 5);
        t = cyc;
        expect_evt("fa_stop", t + 1, 1'b0, 1'b0, 1'b0, 4'd0);
        apply_stimulus(4'd0, 2'b00);
        tick(3);
        pulse_retrigger();
        tick(20);

        $display("[TB] asynchronous reset mid-gap and mid-high phase");
        t = cyc;
        expect_evt("sol2_play", t + 1, 1'b0, 1'b1, 1'b1, 4'd5);
        apply_stimulus(4'd5, 2'b00);
        tick(4);
        t = cyc;
        expect_evt("sol_la_gap", t + 1, 1'b0, 1'b0, 1'b1, 4'd0);
        apply_stimulus(4'd6, 2'b00);
        tick(4);
        async_reset("reset_mid_gap");
        t = cyc;
        expect_evt("ti_high_play", t + 1,         1'b0, 1'b1, 1'b1, 4'd7);
        expect_evt("ti_high_rise", t + 1 + 50619, 1'b1, 1'b1, 1'b1, 4'd7);
        apply_stimulus(4'd7, 2'b10);
        wait_until(t + 1 + 50619 + 10);
        async_reset("reset_mid_high");
        t = cyc;
        expect_evt("do_mid_play", t + 1,          1'b0, 1'b1, 1'b1, 4'd1);
        expect_evt("do_mid_rise", t + 1 + 191110, 1'b1, 1'b1, 1'b1, 4'd1);
        apply_stimulus(4'd1, 2'b00);
        wait_until(t + 1 + 191110 + 5);
        t = cyc;
        expect_evt("do_mid_stop", t + 1, 1'b0, 1'b0, 1'b0, 4'd0);
        apply_stimulus(4'd0, 2'b00);
        tick(3);

        done = 1'b1;
        tick(3);
    end

endmodule

// File: doc/tone_generator.md
Name: tone_generator

Overview:
- Consumer end of the controller's note interface: takes the 4-bit note code and 2-bit octave from the controller and drives the board's mono audio output as a square wave.
- Holds a silent articulation gap between consecutive different notes and on explicit re-strike, so repeated or adjacent notes are audibly separated.
- Sits between the controller and the audio pins.
- Free-running and single-clock; no handshake back to the controller beyond status outputs.

Parameters:
- GAP_CYCLES, 2_000_000, length of the silent gap in clk cycles (20 ms at 100 MHz); must be >= 1.
- CNT_W, 20, width of the half-period counter; must hold the longest half-period (low C = 382220).

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-high reset.
- note_in  in  4  note code: 0 = rest, 1..7 = do..ti (C..B), 8..15 = invalid, treated as rest.
- octave_in  in  2  2'b01 = low, 2'b10 = high, 2'b00/2'b11 = middle.
- retrigger  in  1  one-cycle pulse: re-strike the current note through a gap.
- speaker  out  1  square-wave audio output.
- amp_en  out  1  audio amplifier enable; 1 only in PLAY.
- active_note  out  4  latched note code while in PLAY, else 0.
- busy  out  1  1 in PLAY or GAP.

Behaviour:
- Reset, asynchronous: every output is 0, state = SILENT, all counters are 0, latched note and octave are 0.
- Half-period table, middle octave, in clk cycles: C 191110, D 170265, E 151685, F 143172, G 127551, A 113636, B 101239.
- Low octave = table value shifted left by 1; high octave = table value shifted right by 1. All values fit in CNT_W.
- States: SILENT, PLAY, GAP. All transitions are registered.
- SILENT:
  - speaker = 0, amp_en = 0.
  - If note_in is 1..7: latch note and octave, load the half-period, clear the counter, go to PLAY on the next edge.
  - Otherwise stay in SILENT.
  - retrigger is ignored.
- PLAY:
  - amp_en = 1; counter increments every cycle.
  - When counter == half_period-1: counter <= 0 and speaker toggles.
  - The first speaker rising edge occurs half_period cycles after entry.
  - Input change ({note_in,octave_in} differs from the latched pair):
    - New note is rest or invalid: go to SILENT; speaker and amp_en are 0 from the next cycle.
    - New note is valid: go to GAP; speaker <= 0, gap counter <= 0.
  - retrigger with unchanged input: go to GAP the same way.
  - Input change and retrigger in the same cycle: the input change rule applies.
- GAP:
  - speaker = 0, amp_en = 0, busy = 1, active_note = 0.
  - Gap counter increments. At GAP_CYCLES-1, sample note_in and octave_in:
    - valid: latch, load the half-period, clear the counter, go to PLAY;
    - otherwise: go to SILENT.
  - Input changes and retrigger during GAP do not restart the gap; the value present at gap end wins.
- Octave change alone counts as a change, so it also goes through a gap.
- speaker always returns to 0 on any exit from PLAY; it never freezes high.
- Reset mid-operation, including mid-GAP: immediate return to the reset values.

Decomposition:
- Shared package music_pkg:
  - note code constants NOTE_REST and NOTE_DO..NOTE_TI;
  - octave code constants OCT_LOW, OCT_MID, OCT_HIGH;
  - the seven middle-octave half-period constants;
  - the state encoding for SILENT, PLAY, GAP.
- One sub-module, tone_period_lut: combinational, (note, octave) -> CNT_W half-period. Returns 0 for invalid codes, which the caller never loads.

Test Plan (GAP_CYCLES overridden to 8 unless noted):
- Reset then note_in=6, octave=00 → PLAY one cycle later.
  - amp_en=1, active_note=6.
  - speaker rises 113636 cycles after PLAY entry and falls 113636 cycles after that.
- Note 1 at octave=01 then octave=10 → measured half-periods are 382220 and 95555 respectively.
  - The octave change produces exactly 8 cycles of speaker=0 and amp_en=0 between them.
- Playing note 3; note_in changes to 5, then to 7 mid-gap, then back to 5 before gap end → no gap restart.
  - After 8 cycles, PLAY resumes with note 5 (half-period 127551).
- Playing note 2; note_in=0 → SILENT next cycle, speaker=0, busy=0.
  - Repeat with note_in=9: same response.
- Playing note 4; retrigger pulse → 8-cycle gap, then note 4 restarts with counter=0.
  - A retrigger in SILENT changes nothing.
- Reset asserted asynchronously mid-GAP and mid-high speaker phase → all outputs 0 immediately.
  - After release with note_in=1, the first rising edge comes 191110 cycles after PLAY entry.
